sample_frame_reader: RTL and testbench
======================================

SAMPLE_FRAME_READER -- requirements
Module: sample_frame_reader

Interface
REQ-001 SHALL provide parameters: ADDR_W, default 10, RAM address width; DATA_W, default 12, sample width; FRAME_LEN, default 1024, samples per frame (power of two, ≤ 2^ADDR_W).
REQ-002 SHALL have ports: CLOCK  in  1  single clock, all logic rising-edge.
REQ-003 RESET  in  1  asynchronous, active-low reset.
REQ-004 frame_ready  in  1  one-cycle pulse from the capture writer: frame complete at frame_base.
REQ-005 frame_base  in  ADDR_W  start address of the completed frame, sampled with frame_ready.
REQ-006 can_write_ram  out  1  RAM ownership grant to the writer; low while this block reads.
REQ-007 ram_rd_en  out  1  RAM read strobe.
REQ-008 ram_addr  out  ADDR_W  RAM read address.
REQ-009 ram_rd_data  in  DATA_W  RAM read data, valid exactly one cycle after ram_rd_en.
REQ-010 sample_data  out  DATA_W  streamed sample.
REQ-011 sample_valid  out  1  sample_data valid.
REQ-012 sample_ready  in  1  downstream accepts; transfer when valid && ready.
REQ-013 sample_last  out  1  high with the final sample of a frame.
REQ-014 overrun  out  1  sticky: frame_ready arrived while not IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> READ -> DRAIN -> IDLE.
REQ-016 IDLE: can_write_ram=1; on frame_ready latch frame_base, clear read counter, go READ next cycle.
REQ-017 READ: can_write_ram=0; issue ram_rd_en with ram_addr = base + count (mod 2^ADDR_W, wrap-around allowed) only when buffer occupancy + reads in flight < 2.
REQ-018 READ -> DRAIN after the read for count = FRAME_LEN-1 is issued.
REQ-019 DRAIN: no reads; -> IDLE in the cycle sample_last transfers; can_write_ram returns to 1 the following cycle.
REQ-020 Latency: first sample_valid SHALL assert 3 cycles after frame_ready when sample_ready is held high.
REQ-021 Throughput: one sample per cycle sustained while sample_ready is high.
REQ-022 sample_valid SHALL not drop until transfer; sample_data/sample_last stable while valid && !ready.
REQ-023 Samples SHALL appear in address order, none lost or duplicated under arbitrary sample_ready.
REQ-024 frame_ready outside IDLE: ignored for reading, sets overrun; the frame in progress continues unaffected.
REQ-025 frame_ready and sample_last transfer in the same cycle: counted as overrun, not started.
REQ-026 ram_addr SHALL hold its last value when ram_rd_en=0.

Reset
REQ-027 RESET low SHALL asynchronously force: state IDLE, can_write_ram=1, ram_rd_en=0, ram_addr=0, sample_valid=0, sample_last=0, sample_data=0, overrun=0, buffer empty.
REQ-028 RESET mid-frame SHALL abandon the frame; no partial output after release.
REQ-029 overrun SHALL be cleared only by RESET.

Configuration
REQ-030 Macro READER_DECIM_EN defined: only even-indexed samples (0,2,4,…) are output, FRAME_LEN/2 per frame, sample_last on index FRAME_LEN-2; RAM still read sequentially for every address.
REQ-031 Macro READER_DECIM_EN undefined: all FRAME_LEN samples are output; no decimation logic is present.

Structure
REQ-032 Shared package shazam_pkg SHALL hold the FSM state enum (IDLE, READ, DRAIN) and default ADDR_W/DATA_W/FRAME_LEN constants.
REQ-033 The 2-entry output buffer SHALL be sub-module sample_skid_buffer (DATA_W+1 wide: data and last).

Verification
REQ-034 Reset release, ready=1, frame_ready with base=0 -> valid at cycle +3, 1024 samples equal RAM[0..1023], last on the 1024th, can_write_ram low throughout.
REQ-035 base=1000, FRAME_LEN=1024 -> addresses 1000..1023 then 0..999, data in that order.
REQ-036 sample_ready random 50% -> no loss or duplication, data stable while stalled, ram_rd_en never with 2 outstanding.
REQ-037 Second frame_ready at sample 500 -> overrun=1 and remains set; first frame completes intact; no second frame streamed.
REQ-038 RESET low at sample 300 -> all outputs at reset values immediately; new frame_ready afterwards streams from sample 0.
REQ-039 READER_DECIM_EN defined, base=0 -> 512 samples RAM[0],RAM[2],…,RAM[1022], last on RAM[1022].

Source files
------------

// File: rtl/shazam_pkg.sv
// ============================================================================
//  Module      : shazam_pkg
//  Description : Shared definitions for the sample frame reader. Holds the
//                reader FSM state enum and the default ADDR_W/DATA_W/
//                FRAME_LEN values used as parameter defaults.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package shazam_pkg;

   localparam int unsigned DEF_ADDR_W    = 10;
   localparam int unsigned DEF_DATA_W    = 12;
   localparam int unsigned DEF_FRAME_LEN = 1024;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } reader_state_e;

endpackage : shazam_pkg

`default_nettype wire

// File: rtl/sample_skid_buffer.sv
// ============================================================================
//  Module      : sample_skid_buffer
//  Description : Two-entry FIFO between the RAM read pipeline and the
//                valid/ready sample stream. Entry 0 is always the head, so
//                the output is stable while the consumer stalls.
//  Ports       : clk_i        clock
//                rst_ni       asynchronous active-low reset
//                push_i       write push_data_i (ignored when full w/o pop)
//                push_data_i  {last, data} entry to store
//                pop_i        consumer ready (pops when valid_o is high)
//                valid_o      head entry valid
//                data_o       head entry
//                count_o      current occupancy 0..2
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sample_skid_buffer #(
   parameter int unsigned WIDTH = 13
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic [1:0]       count_o
);

   logic [WIDTH-1:0] entry0_q, entry0_d;
   logic [WIDTH-1:0] entry1_q, entry1_d;
   logic [1:0]       count_q,  count_d;

   logic pop_eff;
   logic push_eff;

   assign pop_eff  = pop_i && (count_q != 2'd0);
   assign push_eff = push_i && ((count_q != 2'd2) || pop_eff);

   always_comb begin
      entry0_d = entry0_q;
      entry1_d = entry1_q;
      count_d  = count_q;
      case ({push_eff, pop_eff})
         2'b10: begin
            if (count_q == 2'd0) entry0_d = push_data_i;
            else                 entry1_d = push_data_i;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            entry0_d = entry1_q;
            count_d  = count_q - 2'd1;
         end
         2'b11: begin
            // Simultaneous push and pop: occupancy unchanged, head advances.
            if (count_q == 2'd1) begin
               entry0_d = push_data_i;
            end else begin
               entry0_d = entry1_q;
               entry1_d = push_data_i;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         entry0_q <= '0;
         entry1_q <= '0;
         count_q  <= 2'd0;
      end else begin
         entry0_q <= entry0_d;
         entry1_q <= entry1_d;
         count_q  <= count_d;
      end
   end

   assign valid_o = (count_q != 2'd0);
   assign data_o  = entry0_q;
   assign count_o = count_q;

endmodule : sample_skid_buffer

`default_nettype wire

// File: rtl/sample_frame_reader.sv
// ============================================================================
//  Module      : sample_frame_reader
//  Description : Reads a completed capture frame out of a shared sample RAM
//                (starting at frame_base, wrapping modulo 2^ADDR_W) and
//                streams it on a valid/ready interface with a last flag.
//                Holds RAM ownership (can_write_ram low) while reading.
//                Optional build macro READER_DECIM_EN: every RAM address is
//                still read, but only even-indexed samples are streamed.
//  Ports       : clk_i            clock, rising edge
//                rst_ni           asynchronous active-low reset
//                frame_ready_i    one-cycle pulse, frame complete
//                frame_base_i     frame start address (with frame_ready_i)
//                can_write_ram_o  RAM ownership grant to the writer
//                ram_rd_en_o      RAM read strobe
//                ram_addr_o       RAM read address (held when not reading)
//                ram_rd_data_i    RAM data, one cycle after ram_rd_en_o
//                sample_data_o    streamed sample
//                sample_valid_o   sample_data_o valid
//                sample_ready_i   downstream accept
//                sample_last_o    final sample of the frame
//                overrun_o        sticky: frame_ready_i seen while busy
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sample_frame_reader
   import shazam_pkg::*;
#(
   parameter int unsigned ADDR_W    = DEF_ADDR_W,
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned FRAME_LEN = DEF_FRAME_LEN
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              frame_ready_i,
   input  logic [ADDR_W-1:0] frame_base_i,
   output logic              can_write_ram_o,
   output logic              ram_rd_en_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   input  logic [DATA_W-1:0] ram_rd_data_i,
   output logic [DATA_W-1:0] sample_data_o,
   output logic              sample_valid_o,
   input  logic              sample_ready_i,
   output logic              sample_last_o,
   output logic              overrun_o
);

   localparam logic [ADDR_W-1:0] LAST_RD_IDX  = ADDR_W'(FRAME_LEN - 1);
`ifdef READER_DECIM_EN
   localparam logic [ADDR_W-1:0] LAST_OUT_IDX = ADDR_W'(FRAME_LEN - 2);
`else
   localparam logic [ADDR_W-1:0] LAST_OUT_IDX = ADDR_W'(FRAME_LEN - 1);
`endif

   reader_state_e     state_q,   state_d;
   logic [ADDR_W-1:0] base_q,    base_d;
   logic [ADDR_W-1:0] count_q,   count_d;
   logic [ADDR_W-1:0] addr_q,    addr_d;
   logic              overrun_q, overrun_d;
   logic              rd_pend_q;
   logic [ADDR_W-1:0] rd_idx_q;

   logic              buf_valid;
   logic [DATA_W:0]   buf_data;
   logic [1:0]        buf_count;
   logic              xfer;
   logic [2:0]        outstanding;
   logic              issue;
   logic              keep;
   logic              push_last;

   assign xfer = buf_valid && sample_ready_i;

   // Samples still owed to the consumer after this cycle's transfer: buffer
   // contents plus the read whose data is on the bus. Counting the transfer
   // lets a read go out every cycle when the consumer keeps up.
   assign outstanding = {1'b0, buf_count} + {2'b00, rd_pend_q} - {2'b00, xfer};
   assign issue       = (state_q == READ) && (outstanding < 3'd2);

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      count_d   = count_q;
      addr_d    = addr_q;
      overrun_d = overrun_q;
      case (state_q)
         IDLE: begin
            if (frame_ready_i) begin
               base_d  = frame_base_i;
               count_d = '0;
               state_d = READ;
            end
         end
         READ: begin
            if (issue) begin
               addr_d  = base_q + count_q;
               count_d = count_q + 1'b1;
               if (count_q == LAST_RD_IDX) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (xfer && buf_data[DATA_W]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A pulse in the same cycle as the final transfer still sees DRAIN
      // here, so it is flagged and not started.
      if (frame_ready_i && (state_q != IDLE)) overrun_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         base_q    <= '0;
         count_q   <= '0;
         addr_q    <= '0;
         overrun_q <= 1'b0;
         rd_pend_q <= 1'b0;
         rd_idx_q  <= '0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         count_q   <= count_d;
         addr_q    <= addr_d;
         overrun_q <= overrun_d;
         rd_pend_q <= issue;
         if (issue) rd_idx_q <= count_q;
      end
   end

`ifdef READER_DECIM_EN
   // Odd-indexed reads return data that is simply dropped.
   assign keep = rd_pend_q && !rd_idx_q[0];
`else
   assign keep = rd_pend_q;
`endif
   assign push_last = (rd_idx_q == LAST_OUT_IDX);

   sample_skid_buffer #(
      .WIDTH (DATA_W + 1)
   ) u_skid (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (keep),
      .push_data_i ({push_last, ram_rd_data_i}),
      .pop_i       (sample_ready_i),
      .valid_o     (buf_valid),
      .data_o      (buf_data),
      .count_o     (buf_count)
   );

   assign can_write_ram_o = (state_q == IDLE);
   assign ram_rd_en_o     = issue;
   assign ram_addr_o      = issue ? (base_q + count_q) : addr_q;
   assign sample_valid_o  = buf_valid;
   assign sample_data_o   = buf_data[DATA_W-1:0];
   assign sample_last_o   = buf_data[DATA_W];
   assign overrun_o       = overrun_q;

endmodule : sample_frame_reader

`default_nettype wire

// File: tb/tb_sample_frame_reader.sv
// ============================================================================
//  Module      : tb_sample_frame_reader
//  Description : Self-checking bench for sample_frame_reader. A RAM model
//                answers reads one cycle later; a scoreboard queue holds the
//                expected {last,data} stream of each started frame and a
//                negedge monitor compares every transfer against it.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sample_frame_reader;

   localparam int AW    = 10;
   localparam int DW    = 12;
   localparam int FL    = 1024;
   localparam int DEPTH = 1 << AW;
`ifdef READER_DECIM_EN
   localparam int STEP = 2;
`else
   localparam int STEP = 1;
`endif
   localparam int NOUT = FL / STEP;

   logic          clk;
   logic          rst_n;
   logic          frame_ready;
   logic [AW-1:0] frame_base;
   logic          can_write_ram;
   logic          ram_rd_en;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_rd_data;
   logic [DW-1:0] sample_data;
   logic          sample_valid;
   logic          sample_ready;
   logic          sample_last;
   logic          overrun;

   sample_frame_reader #(
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .FRAME_LEN (FL)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .frame_ready_i   (frame_ready),
      .frame_base_i    (frame_base),
      .can_write_ram_o (can_write_ram),
      .ram_rd_en_o     (ram_rd_en),
      .ram_addr_o      (ram_addr),
      .ram_rd_data_i   (ram_rd_data),
      .sample_data_o   (sample_data),
      .sample_valid_o  (sample_valid),
      .sample_ready_i  (sample_ready),
      .sample_last_o   (sample_last),
      .overrun_o       (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [DW-1:0] ram [DEPTH];
   always @(posedge clk) if (ram_rd_en) ram_rd_data <= ram[ram_addr];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask

   // 0: ready always high, 1: random 50%, 2: held low
   int ready_mode = 0;
   always @(posedge clk) begin
      #1;
      sample_ready = (ready_mode == 0) ? 1'b1 :
                     (ready_mode == 1) ? 1'($urandom % 2) : 1'b0;
   end

   // ---------------- scoreboard / monitor ----------------
   logic [DW:0] exp_q [$];
   int          exp_base    = 0;
   int          rd_idx      = 0;
   int          frame_xfers = 0;
   int          kept_hist   = 0;
   int          xfers_total = 0;
   int          prev_rd_en  = 0;
   int          prev_kept   = 0;
   bit          prev_stall  = 0;
   logic [DW:0] prev_out;

   always @(negedge clk) begin
      if (!rst_n) begin
         kept_hist   = 0;
         xfers_total = 0;
         prev_rd_en  = 0;
         prev_kept   = 0;
         prev_stall  = 0;
      end else begin
         automatic int xf  = (sample_valid && sample_ready) ? 1 : 0;
         automatic int occ = kept_hist - xfers_total;
         logic [DW:0] e;
         if (ram_rd_en) begin
            chk("rd_outstanding_lt2", 32'((prev_rd_en + occ - xf) < 2), 32'd1);
            chk("rd_addr", 32'(ram_addr), 32'((exp_base + rd_idx) % DEPTH));
            chk("cwr_low_while_reading", 32'(can_write_ram), 32'd0);
         end
         if (prev_stall) begin
            chk("valid_held_on_stall", 32'(sample_valid), 32'd1);
            chk("out_stable_on_stall", 32'({sample_last, sample_data}), 32'(prev_out));
         end
         if (xf == 1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_sample", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("sample_data", 32'(sample_data), 32'(e[DW-1:0]));
               chk("sample_last", 32'(sample_last), 32'(e[DW]));
            end
            frame_xfers++;
         end
         kept_hist  += prev_kept;
         prev_kept   = (ram_rd_en && ((rd_idx % STEP) == 0)) ? 1 : 0;
         prev_rd_en  = ram_rd_en ? 1 : 0;
         if (ram_rd_en) rd_idx++;
         xfers_total += xf;
         prev_stall  = sample_valid && !sample_ready;
         prev_out    = {sample_last, sample_data};
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic start_frame(input int base);
      frame_base  = AW'(base);
      frame_ready = 1'b1;
      exp_base    = base;
      rd_idx      = 0;
      frame_xfers = 0;
      for (int i = 0; i < FL; i += STEP)
         exp_q.push_back({(i == FL - STEP), ram[(base + i) % DEPTH]});
      step();
      frame_ready = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int cyc = 0;
      while ((exp_q.size() != 0 || !can_write_ram) && cyc < 20000) begin
         step();
         cyc++;
      end
      chk(name, 32'(exp_q.size() == 0 && can_write_ram), 32'd1);
   endtask

   task automatic wait_xfers(input int n);
      int cyc = 0;
      while (frame_xfers < n && cyc < 20000) begin
         step();
         cyc++;
      end
      chk("reach_sample_count", 32'(frame_xfers >= n), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cwr"},     32'(can_write_ram), 32'd1);
      chk({tag, "_rd_en"},   32'(ram_rd_en),     32'd0);
      chk({tag, "_addr"},    32'(ram_addr),      32'd0);
      chk({tag, "_valid"},   32'(sample_valid),  32'd0);
      chk({tag, "_last"},    32'(sample_last),   32'd0);
      chk({tag, "_data"},    32'(sample_data),   32'd0);
      chk({tag, "_overrun"}, 32'(overrun),       32'd0);
   endtask

   task automatic check_quiet(input string name, input int cycles);
      int seen = 0;
      for (int i = 0; i < cycles; i++) begin
         step();
         if (sample_valid || ram_rd_en || !can_write_ram) seen++;
      end
      chk(name, 32'(seen), 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst_n        = 1'b0;
      frame_ready  = 1'b0;
      frame_base   = '0;
      sample_ready = 1'b1;
      ram_rd_data  = '0;
      for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      step();
      rst_n = 1'b1;
      step();
      step();

      // Frame at base 0, ready held high: latency and full stream.
      ready_mode = 0;
      start_frame(0);
      chk("cwr_low_after_start", 32'(can_write_ram), 32'd0);
      step();
      chk("valid_not_at_plus2", 32'(sample_valid), 32'd0);
      step();
      chk("valid_at_plus3", 32'(sample_valid), 32'd1);
      wait_done("frame_base0_done");
      chk("frame_base0_count", 32'(frame_xfers), 32'(NOUT));
      chk("overrun_clear_base0", 32'(overrun), 32'd0);

      // Frame wrapping past the top of RAM.
      start_frame(1000);
      wait_done("frame_wrap_done");
      chk("frame_wrap_count", 32'(frame_xfers), 32'(NOUT));

      // Random backpressure.
      ready_mode = 1;
      start_frame(int'($urandom % DEPTH));
      wait_done("frame_random_ready_done");
      chk("frame_random_ready_count", 32'(frame_xfers), 32'(NOUT));

      // Second frame_ready mid-frame: overrun, first frame intact.
      start_frame(int'($urandom % DEPTH));
      wait_xfers(500 / STEP);
      frame_base  = AW'($urandom);
      frame_ready = 1'b1;
      step();
      frame_ready = 1'b0;
      step();
      chk("overrun_set_midframe", 32'(overrun), 32'd1);
      wait_done("frame_overrun_done");
      chk("frame_overrun_count", 32'(frame_xfers), 32'(NOUT));
      check_quiet("no_second_frame", 20);
      chk("overrun_sticky", 32'(overrun), 32'd1);

      // Reset mid-frame.
      ready_mode = 0;
      start_frame(int'($urandom % DEPTH));
      wait_xfers(300 / STEP);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      exp_q.delete();
      step();
      step();
      rst_n = 1'b1;
      check_quiet("no_output_after_reset", 5);
      ready_mode = 1;
      start_frame(int'($urandom % DEPTH));
      wait_done("frame_after_reset_done");
      chk("frame_after_reset_count", 32'(frame_xfers), 32'(NOUT));

      // frame_ready in the same cycle as the final transfer.
      ready_mode = 0;
      start_frame(int'($urandom % DEPTH));
      begin
         int cyc = 0;
         while (!(sample_valid && sample_last && sample_ready) && cyc < 20000) begin
            step();
            cyc++;
         end
         chk("reach_last_sample", 32'(cyc < 20000), 32'd1);
      end
      frame_base  = AW'($urandom);
      frame_ready = 1'b1;
      step();
      frame_ready = 1'b0;
      wait_done("frame_samecycle_done");
      chk("overrun_samecycle", 32'(overrun), 32'd1);
      check_quiet("samecycle_not_started", 20);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_sample_frame_reader

`default_nettype wire
